// File: rtl/fp_pkg.sv
// Shared FP32 types for the multiplier dispatch wrapper.
package fp_pkg;

    localparam int unsigned FP32_W = 32;

    typedef logic [FP32_W-1:0] fp32_t;

    typedef struct packed {
        fp32_t a;
        fp32_t b;
    } fp_pair_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } disp_state_e;

endpackage

// File: rtl/fp_mul_dispatch_if.sv
// Operand source, multiplier pulse/hold port and result sink of the dispatch wrapper.
interface fp_mul_dispatch_if;
    import fp_pkg::*;

    logic  s_valid;
    logic  s_ready;
    fp32_t s_a;
    fp32_t s_b;

    logic  mul_input_valid;
    fp32_t mul_in_a;
    fp32_t mul_in_b;
    fp32_t mul_data_out;
    logic  mul_output_valid;

    logic  m_valid;
    logic  m_ready;
    fp32_t m_data;

    modport slave (
        input  s_valid, s_a, s_b, mul_data_out, mul_output_valid, m_ready,
        output s_ready, mul_input_valid, mul_in_a, mul_in_b, m_valid, m_data
    );

    modport master (
        output s_valid, s_a, s_b, mul_data_out, mul_output_valid, m_ready,
        input  s_ready, mul_input_valid, mul_in_a, mul_in_b, m_valid, m_data
    );

endinterface

// File: rtl/fp_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; no fall-through.
module fp_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == '0);
    assign rdata_c = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full_c;
        do_pop   = pop && !empty_c;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fp_mul_dispatch.sv
// Queues operand pairs, issues them one at a time to a multi-cycle FP32
// multiplier over a pulse/hold port, and queues the products in order.
module fp_mul_dispatch
    import fp_pkg::*;
#(
    parameter int unsigned OP_DEPTH  = 4,
    parameter int unsigned RES_DEPTH = 4,
    parameter int unsigned TIMEOUT   = 128
) (
    input  logic               clk,
    input  logic               reset,
    fp_mul_dispatch_if.slave   bus,
    output logic               busy,
    output logic               err
);

    localparam int unsigned WD_W   = $clog2(TIMEOUT);
    localparam int unsigned PAIR_W = $bits(fp_pair_t);

    disp_state_e       state_q, state_d;
    fp32_t             a_q, a_d;
    fp32_t             b_q, b_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              err_q, err_d;
    logic              issue_q, issue_d;
    logic              busy_q, busy_d;

    logic              op_pop;
    logic              res_push;
    logic              op_full_c, op_empty_c;
    logic              res_full_c, res_empty_c;
    logic [PAIR_W-1:0] op_rdata_c;
    fp32_t             res_rdata_c;
    fp_pair_t          s_pair;
    fp_pair_t          op_head;

    assign s_pair  = '{a: bus.s_a, b: bus.s_b};
    assign op_head = op_rdata_c;

    fp_sync_fifo #(.WIDTH(PAIR_W), .DEPTH(OP_DEPTH)) u_op_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (bus.s_valid),
        .wdata   (s_pair),
        .pop     (op_pop),
        .rdata_c (op_rdata_c),
        .full_c  (op_full_c),
        .empty_c (op_empty_c)
    );

    fp_sync_fifo #(.WIDTH(FP32_W), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (res_push),
        .wdata   (bus.mul_data_out),
        .pop     (bus.m_ready),
        .rdata_c (res_rdata_c),
        .full_c  (res_full_c),
        .empty_c (res_empty_c)
    );

    // Issue gate reserves a result slot, so a completed op can always be stored.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        wd_d     = wd_q;
        err_d    = err_q;
        op_pop   = 1'b0;
        res_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (!op_empty_c && !res_full_c) begin
                    state_d = ISSUE;
                    op_pop  = 1'b1;
                    a_d     = op_head.a;
                    b_d     = op_head.b;
                    wd_d    = '0;
                end
            end
            ISSUE: begin
                state_d = BUSY;
                wd_d    = wd_q + WD_W'(1);
            end
            BUSY: begin
                if (bus.mul_output_valid) begin
                    state_d  = GAP;
                    res_push = 1'b1;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A strobe with no op outstanding is a protocol error; its data is ignored.
        if (bus.mul_output_valid && (state_q != BUSY)) begin
            err_d = 1'b1;
        end
        issue_d = (state_d == ISSUE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            issue_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            issue_q <= issue_d;
            busy_q  <= busy_d;
            assert (!(res_push && res_full_c));
        end
    end

    assign bus.s_ready         = !op_full_c;
    assign bus.mul_input_valid = issue_q;
    assign bus.mul_in_a        = a_q;
    assign bus.mul_in_b        = b_q;
    assign bus.m_valid         = !res_empty_c;
    assign bus.m_data          = res_rdata_c;
    assign busy                = busy_q;
    assign err                 = err_q;

endmodule

// File: tb/tb_fp_mul_dispatch.sv
// Self-checking bench: behavioural multiplier, in-order result scoreboard, directed and random traffic.
module tb_fp_mul_dispatch;
    import fp_pkg::*;

    localparam int unsigned TIMEOUT = 128;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic err;

    int n_checks = 0;
    int n_fail   = 0;

    fp_pair_t op_q[$];
    fp32_t    res_q[$];
    fp32_t    got_q[$];

    int       pulse_cnt    = 0;
    bit       stub_real    = 1'b1;
    int       stub_lat     = 5;
    bit       stub_rand    = 1'b0;
    bit       stub_pending = 1'b0;
    int       stub_cnt     = 0;
    fp_pair_t stub_op;
    bit       stub_drop    = 1'b0;
    bit       stub_fired   = 1'b0;
    bit       stray_req    = 1'b0;
    bit       prev_pulse   = 1'b0;
    int       sink_mode    = 0;

    fp_mul_dispatch_if bus ();

    fp_mul_dispatch #(.OP_DEPTH(4), .RES_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Truncating FP32 multiply for normal operands with in-range exponents.
    function automatic fp32_t fmul(input fp32_t a, input fp32_t b);
        logic [47:0] ma, mb, p;
        logic [22:0] fr;
        int          e;
        ma = {24'd0, 1'b1, a[22:0]};
        mb = {24'd0, 1'b1, b[22:0]};
        p  = ma * mb;
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            fr = p[46:24];
            e  = e + 1;
        end else begin
            fr = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], fr};
    endfunction

    function automatic fp32_t rand_fp();
        return {1'($urandom_range(1, 0)), 8'($urandom_range(150, 100)), 23'($urandom)};
    endfunction

    // Sink and multiplier behaviour, evaluated once per falling edge.
    task automatic env_step();
        fp32_t exp_p;
        case (sink_mode)
            0:       bus.m_ready = 1'b0;
            1:       bus.m_ready = 1'b1;
            default: bus.m_ready = 1'($urandom_range(1, 0));
        endcase
        if (!reset && bus.m_valid && bus.m_ready) begin
            got_q.push_back(bus.m_data);
            chk("result_expected", 32'(res_q.size() != 0), 1);
            if (res_q.size() != 0) begin
                exp_p = res_q.pop_front();
                chk("m_data_order", bus.m_data, exp_p);
            end
        end

        if (stub_fired) begin
            bus.mul_output_valid = 1'b0;
            stub_fired           = 1'b0;
        end
        if (prev_pulse) chk("pulse_width", bus.mul_input_valid, 0);
        if (stub_pending) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                if (!stub_drop) begin
                    chk("hold_a", bus.mul_in_a, stub_op.a);
                    chk("hold_b", bus.mul_in_b, stub_op.b);
                    res_q.push_back(fmul(stub_op.a, stub_op.b));
                end
                bus.mul_data_out     = fmul(stub_op.a, stub_op.b);
                bus.mul_output_valid = 1'b1;
                stub_fired           = 1'b1;
                stub_pending         = 1'b0;
                stub_drop            = 1'b0;
            end
        end
        if (stray_req) begin
            bus.mul_data_out     = 32'hDEAD_BEEF;
            bus.mul_output_valid = 1'b1;
            stub_fired           = 1'b1;
            stray_req            = 1'b0;
        end
        prev_pulse = bus.mul_input_valid;
        if (bus.mul_input_valid) begin
            pulse_cnt++;
            chk("pulse_has_op", 32'(op_q.size() != 0), 1);
            if (op_q.size() != 0) begin
                stub_op = op_q.pop_front();
                chk("issue_a", bus.mul_in_a, stub_op.a);
                chk("issue_b", bus.mul_in_b, stub_op.b);
                if (stub_real) begin
                    stub_pending = 1'b1;
                    stub_cnt     = stub_rand ? int'($urandom_range(6, 2)) : stub_lat;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        env_step();
    endtask

    task automatic push_op(input fp32_t a, input fp32_t b);
        bit acc = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_a     = a;
        bus.s_b     = b;
        for (int i = 0; i < 2000 && !acc; i++) begin
            if (bus.s_ready) begin
                op_q.push_back('{a: a, b: b});
                acc = 1'b1;
            end
            tick();
        end
        bus.s_valid = 1'b0;
        chk("push_accepted", 32'(acc), 1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            done = (op_q.size() == 0) && (res_q.size() == 0) && !stub_pending && !busy;
        end
        chk(tag, 32'(done), 1);
    endtask

    task automatic do_reset(input int n);
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        op_q.delete();
        res_q.delete();
        stub_drop  = stub_pending;
        prev_pulse = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    initial begin
        fp32_t dir_a [4];
        fp32_t dir_b [4];
        fp32_t dir_p [4];
        int    base;
        bit    found;

        dir_a = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000};
        dir_b = '{32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 32'hBF80_0000};
        dir_p = '{32'h3F80_0000, 32'h4080_0000, 32'h4040_0000, 32'hBF80_0000};

        reset                = 1'b1;
        bus.s_valid          = 1'b0;
        bus.s_a              = '0;
        bus.s_b              = '0;
        bus.m_ready          = 1'b0;
        bus.mul_output_valid = 1'b0;
        bus.mul_data_out     = '0;

        // Reset state
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_pulse", bus.mul_input_valid, 0);
        chk("rst_in_a", bus.mul_in_a, 0);
        chk("rst_in_b", bus.mul_in_b, 0);
        chk("rst_m_data", bus.m_data, 0);

        // Single op: latency to pulse and product
        sink_mode = 1;
        got_q.delete();
        push_op(32'h3FC0_0000, 32'h4000_0000);
        chk("lat_first_cycle", bus.mul_input_valid, 0);
        tick();
        chk("lat_pulse", bus.mul_input_valid, 1);
        chk("busy_at_pulse", busy, 1);
        wait_drain("drain_single", 200);
        chk("single_count", got_q.size(), 1);
        chk("single_product", got_q[0], 32'h4040_0000);

        // Four back-to-back directed ops, in order
        got_q.delete();
        for (int i = 0; i < 4; i++) push_op(dir_a[i], dir_b[i]);
        wait_drain("drain_directed", 400);
        chk("directed_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("directed_order", got_q[i], dir_p[i]);

        // Random traffic with random multiplier latency and sink backpressure
        stub_rand = 1'b1;
        sink_mode = 2;
        got_q.delete();
        for (int i = 0; i < 40; i++) begin
            push_op(rand_fp(), rand_fp());
            repeat ($urandom_range(2, 0)) tick();
        end
        wait_drain("drain_random", 3000);
        chk("random_count", got_q.size(), 40);
        stub_rand = 1'b0;

        // Result FIFO full: no issue; operand FIFO full: s_ready low
        sink_mode = 0;
        got_q.delete();
        base = pulse_cnt;
        for (int i = 0; i < 6; i++) push_op(rand_fp(), rand_fp());
        repeat (100) tick();
        chk("full_pulses", pulse_cnt - base, 4);
        chk("full_m_valid", bus.m_valid, 1);
        chk("full_idle", busy, 0);
        chk("two_stored_s_ready", bus.s_ready, 1);
        push_op(rand_fp(), rand_fp());
        push_op(rand_fp(), rand_fp());
        chk("op_full_s_ready", bus.s_ready, 0);
        bus.s_valid = 1'b1;
        bus.s_a     = rand_fp();
        bus.s_b     = rand_fp();
        for (int i = 0; i < 5; i++) begin
            chk("stall_s_ready", bus.s_ready, 0);
            tick();
        end
        bus.s_valid = 1'b0;
        chk("stall_no_pulse", pulse_cnt - base, 4);
        sink_mode = 1;
        wait_drain("drain_full", 1000);
        chk("full_drain_count", got_q.size(), 8);

        // Watchdog: multiplier never answers
        stub_real = 1'b0;
        push_op(rand_fp(), rand_fp());
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            found = bus.mul_input_valid;
        end
        chk("wd_pulse_seen", 32'(found), 1);
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            tick();
            if (k == int'(TIMEOUT) - 1) begin
                chk("wd_err_early", err, 0);
                chk("wd_busy_early", busy, 1);
            end
            if (k == int'(TIMEOUT)) begin
                chk("wd_err_set", err, 1);
                chk("wd_idle", busy, 0);
            end
        end
        stub_real = 1'b1;
        got_q.delete();
        push_op(32'h4000_0000, 32'h4040_0000);
        wait_drain("drain_after_wd", 200);
        chk("after_wd_count", got_q.size(), 1);
        chk("after_wd_product", got_q[0], 32'h40C0_0000);
        chk("err_sticky", err, 1);

        // Stray strobe while idle
        do_reset(2);
        chk("reset_clears_err", err, 0);
        stray_req = 1'b1;
        tick();
        tick();
        chk("stray_err", err, 1);
        chk("stray_no_result", bus.m_valid, 0);

        // Reset during BUSY with ops queued; late strobe afterwards
        do_reset(2);
        stub_lat  = 40;
        sink_mode = 0;
        for (int i = 0; i < 4; i++) push_op(rand_fp(), rand_fp());
        repeat (3) tick();
        chk("mid_busy", busy, 1);
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        op_q.delete();
        res_q.delete();
        stub_drop  = stub_pending;
        prev_pulse = 1'b0;
        tick();
        chk("mid_rst_s_ready", bus.s_ready, 1);
        chk("mid_rst_m_valid", bus.m_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pulse", bus.mul_input_valid, 0);
        reset = 1'b0;
        base  = pulse_cnt;
        repeat (60) tick();
        chk("late_strobe_fired", 32'(stub_pending), 0);
        chk("late_no_result", bus.m_valid, 0);
        chk("late_no_issue", pulse_cnt - base, 0);
        chk("late_stray_err", err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
